// File: rtl/dyna_tree_host.sv
// dyna_tree_host: sequences one write or read command into a broadcast tree,
// holds it for SETTLE cycles, idles one cycle, then returns the root value.
`default_nettype none

module dyna_tree_host #(
    parameter int HBIT       = 7,
    parameter int TREE_LEVEL = 4,
    parameter int SETTLE     = TREE_LEVEL + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_op,
    input  logic [HBIT:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [HBIT:0] rsp_data,
    output logic [1:0]    glob_com,
    output logic [HBIT:0] tree_din,
    input  logic [HBIT:0] tree_dout,
    output logic          busy
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               alive;
    logic               op_q;
    logic [HBIT:0]      data_q;
    logic [HBIT:0]      rsp_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // alive keeps req_ready low until the first edge after reset release
    assign req_ready = alive && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_q;
    assign tree_din  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            alive  <= 1'b0;
            op_q   <= 1'b0;
            data_q <= '0;
            cnt    <= '0;
            rsp_q  <= '0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            if (accept) begin
                op_q   <= req_op;
                data_q <= req_data;
                cnt    <= '0;
            end else if ((state == CMD) && (cnt != CNT_LAST)) begin
                cnt <= cnt + 1'b1;
            end
            if (state == GAP) begin
                rsp_q <= tree_dout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        glob_com  = 2'd0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = CMD;
            end
            CMD: begin
                glob_com = op_q ? 2'd2 : 2'd1;
                if (cnt == CNT_LAST) state_nxt = GAP;
            end
            GAP: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dyna_tree_host.sv
// Bench for dyna_tree_host: a small tree stub, a timeline model of the host
// and directed operations with hand-computed expectations.
`default_nettype none

module tb_dyna_tree_host;

    localparam int HBIT       = 7;
    localparam int TREE_LEVEL = 4;
    localparam int SETTLE     = 6;
    localparam int W          = HBIT + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [HBIT:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [HBIT:0] rsp_data;
    logic [1:0]    glob_com;
    logic [HBIT:0] tree_din;
    logic [HBIT:0] tree_dout;
    logic          busy;

    int tests = 0;
    int fails = 0;

    dyna_tree_host #(
        .HBIT       (HBIT),
        .TREE_LEVEL (TREE_LEVEL),
        .SETTLE     (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .glob_com  (glob_com),
        .tree_din  (tree_din),
        .tree_dout (tree_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Tree stub: WRITE stores the root data, READ selects the stored value,
    // otherwise the root shows the inverted stored value.
    logic [HBIT:0] mem     = '0;
    logic          rd_mode = 1'b0;
    always @(posedge clk) begin
        if (glob_com == 2'd1) begin
            mem     <= tree_din;
            rd_mode <= 1'b0;
        end else if (glob_com == 2'd2) begin
            rd_mode <= 1'b1;
        end
    end
    assign tree_dout = rd_mode ? mem : ~mem;

    // Timeline model: m_t counts cycles since acceptance.
    bit            m_alive = 1'b0;
    bit            m_busy  = 1'b0;
    bit            m_op    = 1'b0;
    int            m_t     = 0;
    logic [HBIT:0] m_data  = '0;
    logic [HBIT:0] m_rsp   = '0;
    logic [HBIT:0] m_last  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_alive <= 1'b0;
            m_busy  <= 1'b0;
            m_op    <= 1'b0;
            m_t     <= 0;
            m_data  <= '0;
            m_rsp   <= '0;
        end else begin
            m_alive <= 1'b1;
            if (!m_busy) begin
                if (m_alive && req_valid) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                    m_op   <= req_op;
                    m_data <= req_data;
                    if (!req_op) m_last <= req_data;
                end
            end else if (m_t < SETTLE) begin
                m_t <= m_t + 1;
            end else if (m_t == SETTLE) begin
                m_t   <= m_t + 1;
                m_rsp <= m_op ? m_last : ~m_data;
            end else if (rsp_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", 32'(req_ready), 32'(m_alive && !m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("glob_com", 32'(glob_com),
                  (m_busy && m_t < SETTLE) ? (m_op ? 32'd2 : 32'd1) : 32'd0);
            check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_t == SETTLE + 1));
            if (m_busy) check("tree_din", 32'(tree_din), 32'(m_data));
            if (m_busy && m_t == SETTLE + 1) check("rsp_data", 32'(rsp_data), 32'(m_rsp));
        end
    end

    task automatic run_op(input bit op, input logic [HBIT:0] data, input int hold,
                          input bit junk, output logic [HBIT:0] got,
                          output int lat, output int ncmd, output int ngap);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        rsp_ready = 1'b0;
        guard     = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat  = 1;
        ncmd = 0;
        ngap = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 30) begin
            if (glob_com == (op ? 2'd2 : 2'd1)) ncmd++;
            else if (busy && glob_com == 2'd0) ngap++;
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 1'($urandom_range(0, 1));
                req_data  = W'($urandom_range(0, 255));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        got = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold_data", 32'(rsp_data), 32'(got));
            check("rsp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", 32'(req_ready), 32'd1);
        check("rsp_dropped", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HBIT:0] got;
        int lat, ncmd, ngap, idle_cnt, rsp_cnt, bad_com, rv_cnt, guard;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_glob_com", 32'(glob_com), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_tree_din", 32'(tree_din), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // write 0x10: stub acknowledges with the inverted stored value
        run_op(1'b0, 8'h10, 0, 1'b0, got, lat, ncmd, ngap);
        check("wr_latency", 32'(lat), 32'd8);
        check("wr_cmd_cycles", 32'(ncmd), 32'd6);
        check("wr_gap_cycles", 32'(ngap), 32'd1);
        check("wr_ack_data", 32'(got), 32'hEF);

        run_op(1'b1, 8'h00, 5, 1'b0, got, lat, ncmd, ngap);
        check("rd_latency", 32'(lat), 32'd8);
        check("rd_cmd_cycles", 32'(ncmd), 32'd6);
        check("rd_data", 32'(got), 32'h10);

        // request noise while busy must not disturb the latched write
        run_op(1'b0, 8'hA3, 2, 1'b1, got, lat, ncmd, ngap);
        check("junk_cmd_cycles", 32'(ncmd), 32'd6);
        check("junk_ack_data", 32'(got), 32'h5C);
        run_op(1'b1, 8'hFF, 0, 1'b0, got, lat, ncmd, ngap);
        check("junk_rd_data", 32'(got), 32'hA3);

        // reset in the middle of a write command
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 8'h55;
        guard     = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_com", 32'(glob_com), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_glob_com", 32'(glob_com), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_tree_din", 32'(tree_din), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) rv_cnt++;
        end
        check("abort_no_rsp", 32'(rv_cnt), 32'd0);
        run_op(1'b1, 8'h00, 1, 1'b0, got, lat, ncmd, ngap);
        check("post_abort_lat", 32'(lat), 32'd8);
        check("post_abort_rd", 32'(got), 32'h55);

        // back-to-back with rsp_ready tied high: period IDLE+6 CMD+GAP+RESP
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = 8'h3C;
        rsp_ready = 1'b1;
        idle_cnt  = 0;
        rsp_cnt   = 0;
        bad_com   = 0;
        for (int k = 0; k < 27; k++) begin
            if (req_ready) begin
                idle_cnt++;
                req_op   = ~req_op;
                req_data = req_data + 8'h11;
            end
            if (rsp_valid) rsp_cnt++;
            if (glob_com == 2'd3) bad_com++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_idle_cycles", 32'(idle_cnt), 32'd3);
        check("b2b_responses", 32'(rsp_cnt), 32'd3);
        check("b2b_no_com3", 32'(bad_com), 32'd0);
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
